// File: rtl/watchdog_supervisor_if.sv
// Interface bundling the watchdog_supervisor control and status signals.
// The slave modport is the supervisor's view; the master modport belongs to whoever drives it.
interface watchdog_supervisor_if #(
    parameter int N_SRC  = 4,
    parameter int FCNT_W = 4
);
    logic              arm;
    logic              disarm;
    logic [N_SRC-1:0]  src_mask;
    logic [N_SRC-1:0]  kick;
    logic              sw_force;
    logic              clear_lockout;
    logic              wd_triggered;
    logic              wd_warning;
    logic              wd_rstn;
    logic              wd_enable;
    logic              wd_heartbeat;
    logic              wd_force_reset;
    logic              rf_mute;
    logic              warn_irq;
    logic [N_SRC-1:0]  kick_pending;
    logic [FCNT_W-1:0] fault_count;
    logic [2:0]        state;

    modport slave (
        input  arm, disarm, src_mask, kick, sw_force, clear_lockout,
               wd_triggered, wd_warning,
        output wd_rstn, wd_enable, wd_heartbeat, wd_force_reset, rf_mute,
               warn_irq, kick_pending, fault_count, state
    );

    modport master (
        output arm, disarm, src_mask, kick, sw_force, clear_lockout,
               wd_triggered, wd_warning,
        input  wd_rstn, wd_enable, wd_heartbeat, wd_force_reset, rf_mute,
               warn_irq, kick_pending, fault_count, state
    );
endinterface

// File: rtl/watchdog_supervisor.sv
// Watchdog supervisor: merges per-subsystem kicks into one heartbeat, mutes RF on a trip,
// restarts the watchdog after a holdoff and locks out after repeated faults.
module watchdog_supervisor #(
    parameter int N_SRC          = 4,
    parameter int HOLDOFF_CYCLES = 1024,
    parameter int RESTART_CYCLES = 2,
    parameter int MAX_FAULTS     = 3,
    parameter int FCNT_W         = 4
) (
    input logic clk,
    input logic rstn,
    watchdog_supervisor_if.slave bus
);
    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam int RST_W  = $clog2(RESTART_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESTART_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_FAULT   = 3'd2,
        S_RESTART = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [N_SRC-1:0]   r_mask, w_mask_nxt;
    logic [N_SRC-1:0]   r_seen, w_seen_nxt;
    logic [N_SRC-1:0]   r_pending, w_pending_nxt;
    logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
    logic [RST_W-1:0]   r_rcnt, w_rcnt_nxt;
    logic [FCNT_W-1:0]  r_fault_count, w_fcnt_nxt;
    logic               r_heartbeat, w_hb_nxt;
    logic               r_force, w_force_nxt;
    logic               r_warn_irq, w_warn_nxt;
    logic               r_warn_d;
    logic               r_wd_rstn, r_wd_enable, r_rf_mute;
    logic [N_SRC-1:0]   w_seen_acc;
    logic               w_complete;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt   = r_state;
        w_mask_nxt    = r_mask;
        w_seen_nxt    = '0;
        w_pending_nxt = '0;
        w_hold_nxt    = '0;
        w_rcnt_nxt    = '0;
        w_fcnt_nxt    = r_fault_count;
        w_hb_nxt      = 1'b0;
        w_force_nxt   = 1'b0;
        w_warn_nxt    = 1'b0;
        w_seen_acc    = r_seen | (bus.kick & r_mask);
        w_complete    = (r_mask != '0) && (w_seen_acc == r_mask);

        case (r_state)
            S_IDLE: begin
                if (bus.arm) begin
                    w_state_nxt   = S_ARMED;
                    w_mask_nxt    = bus.src_mask;
                    w_pending_nxt = bus.src_mask;
                end
            end
            S_ARMED: begin
                w_warn_nxt = bus.wd_warning && !r_warn_d;
                if (bus.wd_triggered) begin
                    w_state_nxt = S_FAULT;
                    if (r_fault_count != '1) w_fcnt_nxt = r_fault_count + FCNT_W'(1);
                end else if (bus.disarm) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_force_nxt   = bus.sw_force;
                    // Pending shows the completing kick as consumed for one cycle before the new round.
                    w_pending_nxt = r_mask & ~w_seen_acc;
                    if (w_complete) w_hb_nxt   = 1'b1;
                    else            w_seen_nxt = w_seen_acc;
                end
            end
            S_FAULT: begin
                if (r_hold == HOLD_LAST) begin
                    w_state_nxt = (int'(r_fault_count) >= MAX_FAULTS) ? S_LOCKOUT : S_RESTART;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            S_RESTART: begin
                if (r_rcnt == RST_LAST) begin
                    w_state_nxt   = S_ARMED;
                    w_pending_nxt = r_mask;
                end else begin
                    w_rcnt_nxt = r_rcnt + RST_W'(1);
                end
            end
            S_LOCKOUT: begin
                if (bus.clear_lockout) begin
                    w_state_nxt = S_IDLE;
                    w_fcnt_nxt  = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_mask        <= '0;
            r_seen        <= '0;
            r_pending     <= '0;
            r_hold        <= '0;
            r_rcnt        <= '0;
            r_fault_count <= '0;
            r_heartbeat   <= 1'b0;
            r_force       <= 1'b0;
            r_warn_irq    <= 1'b0;
            r_warn_d      <= 1'b0;
            r_wd_rstn     <= 1'b0;
            r_wd_enable   <= 1'b0;
            r_rf_mute     <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_mask        <= w_mask_nxt;
            r_seen        <= w_seen_nxt;
            r_pending     <= w_pending_nxt;
            r_hold        <= w_hold_nxt;
            r_rcnt        <= w_rcnt_nxt;
            r_fault_count <= w_fcnt_nxt;
            r_heartbeat   <= w_hb_nxt;
            r_force       <= w_force_nxt;
            r_warn_irq    <= w_warn_nxt;
            r_warn_d      <= bus.wd_warning;
            r_wd_rstn     <= (w_state_nxt != S_RESTART);
            r_wd_enable   <= (w_state_nxt == S_ARMED);
            r_rf_mute     <= (w_state_nxt == S_FAULT) || (w_state_nxt == S_RESTART) ||
                             (w_state_nxt == S_LOCKOUT);
        end
    end

    assign bus.wd_rstn        = r_wd_rstn;
    assign bus.wd_enable      = r_wd_enable;
    assign bus.wd_heartbeat   = r_heartbeat;
    assign bus.wd_force_reset = r_force;
    assign bus.rf_mute        = r_rf_mute;
    assign bus.warn_irq       = r_warn_irq;
    assign bus.kick_pending   = r_pending;
    assign bus.fault_count    = r_fault_count;
    assign bus.state          = r_state;
endmodule

// File: tb/tb_watchdog_supervisor.sv
// Directed testbench for watchdog_supervisor with a short holdoff so fault paths stay brief.
module tb_watchdog_supervisor;
    localparam int N_SRC  = 4;
    localparam int FCNT_W = 4;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    watchdog_supervisor_if #(.N_SRC(N_SRC), .FCNT_W(FCNT_W)) bus ();

    watchdog_supervisor #(
        .N_SRC(N_SRC), .HOLDOFF_CYCLES(8), .RESTART_CYCLES(2), .MAX_FAULTS(3), .FCNT_W(FCNT_W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, wd_rstn, wd_enable, rf_mute}
    function automatic logic [5:0] flags();
        return {bus.state, bus.wd_rstn, bus.wd_enable, bus.rf_mute};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.arm = 0; bus.disarm = 0; bus.src_mask = '0; bus.kick = '0;
        bus.sw_force = 0; bus.clear_lockout = 0; bus.wd_triggered = 0; bus.wd_warning = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        step();
        n_tests++;
        if (flags() !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL reset_flags: got %b expected %b", flags(), {3'd0, 3'b001});
        end
        n_tests++;
        if ({bus.wd_heartbeat, bus.wd_force_reset, bus.warn_irq, bus.kick_pending, bus.fault_count} !== 11'd0) begin
            n_fail++; $display("FAIL reset_outputs: hb=%b frc=%b warn=%b pend=%b fcnt=%0d", bus.wd_heartbeat,
                               bus.wd_force_reset, bus.warn_irq, bus.kick_pending, bus.fault_count);
        end
        rstn = 1'b1;
        step();
        n_tests++;
        if (flags() !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_release_idle: got %b expected %b", flags(), {3'd0, 3'b100});
        end
    endtask

    task automatic test_heartbeat();
        logic [3:0] kicks [7]   = '{4'b0001, 4'b0010, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b1010};
        logic [3:0] exp_pend[7] = '{4'b1010, 4'b1000, 4'b0000, 4'b1011, 4'b1010, 4'b1010, 4'b0000};
        logic       exp_hb  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.arm = 1; bus.src_mask = 4'b1011;
        step();
        bus.arm = 0; bus.src_mask = '0;
        n_tests++;
        if ({flags(), bus.kick_pending} !== {3'd1, 3'b110, 4'b1011}) begin
            n_fail++; $display("FAIL arm_entry: got %b/%b expected 001110/1011", flags(), bus.kick_pending);
        end
        for (int i = 0; i < 7; i++) begin
            bus.kick = kicks[i];
            step();
            n_tests++;
            if ({bus.wd_heartbeat, bus.kick_pending} !== {exp_hb[i], exp_pend[i]}) begin
                n_fail++; $display("FAIL kick_round[%0d]: got hb=%b pend=%b expected hb=%b pend=%b", i,
                                   bus.wd_heartbeat, bus.kick_pending, exp_hb[i], exp_pend[i]);
            end
        end
        bus.kick = 4'b0100;
        step();
        n_tests++;
        if ({bus.wd_heartbeat, bus.kick_pending} !== 5'b0_1011) begin
            n_fail++; $display("FAIL unmasked_kick: got hb=%b pend=%b expected 0/1011", bus.wd_heartbeat, bus.kick_pending);
        end
        bus.kick = '0; bus.disarm = 1;
        step();
        bus.disarm = 0;
        n_tests++;
        if ({flags(), bus.kick_pending} !== {3'd0, 3'b100, 4'b0000}) begin
            n_fail++; $display("FAIL disarm: got %b/%b expected 000100/0000", flags(), bus.kick_pending);
        end
    endtask

    task automatic test_mask_zero();
        bus.arm = 1; bus.src_mask = 4'b0000;
        step();
        bus.arm = 0;
        bus.kick = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({bus.state, bus.wd_heartbeat, bus.kick_pending} !== {3'd1, 1'b0, 4'b0000}) begin
                n_fail++; $display("FAIL mask_zero[%0d]: got st=%0d hb=%b pend=%b expected 1/0/0000", i,
                                   bus.state, bus.wd_heartbeat, bus.kick_pending);
            end
        end
        bus.kick = '0; bus.disarm = 1;
        step();
        bus.disarm = 0;
    endtask

    task automatic test_force_warn();
        bus.arm = 1; bus.src_mask = 4'b0001;
        step();
        bus.arm = 0;
        bus.sw_force = 1;
        step();
        bus.sw_force = 0;
        n_tests++;
        if (bus.wd_force_reset !== 1'b1) begin
            n_fail++; $display("FAIL force_armed: got %b expected 1", bus.wd_force_reset);
        end
        step();
        n_tests++;
        if (bus.wd_force_reset !== 1'b0) begin
            n_fail++; $display("FAIL force_one_cycle: got %b expected 0", bus.wd_force_reset);
        end
        bus.wd_warning = 1;
        step();
        n_tests++;
        if (bus.warn_irq !== 1'b1) begin
            n_fail++; $display("FAIL warn_armed: got %b expected 1", bus.warn_irq);
        end
        step();
        n_tests++;
        if (bus.warn_irq !== 1'b0) begin
            n_fail++; $display("FAIL warn_one_cycle: got %b expected 0", bus.warn_irq);
        end
        bus.wd_warning = 0; bus.disarm = 1;
        step();
        bus.disarm = 0; bus.sw_force = 1;
        step();
        bus.sw_force = 0; bus.wd_warning = 1;
        n_tests++;
        if ({bus.state, bus.wd_force_reset} !== {3'd0, 1'b0}) begin
            n_fail++; $display("FAIL force_idle: got st=%0d frc=%b expected 0/0", bus.state, bus.wd_force_reset);
        end
        step();
        bus.wd_warning = 0;
        n_tests++;
        if (bus.warn_irq !== 1'b0) begin
            n_fail++; $display("FAIL warn_idle: got %b expected 0", bus.warn_irq);
        end
        step();
    endtask

    // Walks the 8-cycle holdoff from the first FAULT cycle; ends one edge after the holdoff.
    task automatic hold_fault(input string name, input logic [3:0] exp_fc);
        for (int i = 0; i < 7; i++) begin
            if (i == 1) begin
                bus.arm = 1; bus.disarm = 1; bus.kick = 4'b1111; bus.wd_triggered = 1;
            end
            step();
            bus.arm = 0; bus.disarm = 0; bus.kick = '0; bus.wd_triggered = 0;
            n_tests++;
            if ({flags(), bus.fault_count} !== {3'd2, 3'b101, exp_fc}) begin
                n_fail++; $display("FAIL %s_hold[%0d]: got %b/%0d expected 010101/%0d", name, i,
                                   flags(), bus.fault_count, exp_fc);
            end
        end
        step();
    endtask

    task automatic pass_restart(input string name);
        n_tests++;
        if (flags() !== {3'd3, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL %s_restart0: got %b expected 011001", name, flags());
        end
        step();
        n_tests++;
        if (flags() !== {3'd3, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL %s_restart1: got %b expected 011001", name, flags());
        end
        step();
        n_tests++;
        if ({flags(), bus.kick_pending} !== {3'd1, 3'b110, 4'b0011}) begin
            n_fail++; $display("FAIL %s_rearmed: got %b/%b expected 001110/0011", name, flags(), bus.kick_pending);
        end
    endtask

    task automatic test_trigger_wins();
        bus.arm = 1; bus.src_mask = 4'b0011;
        step();
        bus.arm = 0;
        bus.kick = 4'b0011; bus.wd_triggered = 1; bus.disarm = 1; bus.sw_force = 1;
        step();
        bus.kick = '0; bus.wd_triggered = 0; bus.disarm = 0; bus.sw_force = 0;
        n_tests++;
        if ({flags(), bus.wd_heartbeat, bus.wd_force_reset, bus.fault_count} !== {3'd2, 3'b101, 2'b00, 4'd1}) begin
            n_fail++; $display("FAIL trigger_wins: got %b hb=%b frc=%b fc=%0d expected 010101 hb=0 frc=0 fc=1",
                               flags(), bus.wd_heartbeat, bus.wd_force_reset, bus.fault_count);
        end
        hold_fault("f1", 4'd1);
        pass_restart("f1");
    endtask

    task automatic test_lockout();
        bus.wd_triggered = 1;
        step();
        bus.wd_triggered = 0;
        hold_fault("f2", 4'd2);
        pass_restart("f2");
        bus.wd_triggered = 1;
        step();
        bus.wd_triggered = 0;
        hold_fault("f3", 4'd3);
        n_tests++;
        if ({flags(), bus.fault_count} !== {3'd4, 3'b101, 4'd3}) begin
            n_fail++; $display("FAIL lockout_entry: got %b/%0d expected 100101/3", flags(), bus.fault_count);
        end
        bus.arm = 1; bus.src_mask = 4'b0001;
        step();
        bus.arm = 0;
        n_tests++;
        if (flags() !== {3'd4, 3'b101}) begin
            n_fail++; $display("FAIL lockout_arm_ignored: got %b expected 100101", flags());
        end
        bus.clear_lockout = 1;
        step();
        bus.clear_lockout = 0;
        n_tests++;
        if ({flags(), bus.fault_count} !== {3'd0, 3'b100, 4'd0}) begin
            n_fail++; $display("FAIL clear_lockout: got %b/%0d expected 000100/0", flags(), bus.fault_count);
        end
    endtask

    task automatic test_reset_mid_restart();
        bus.arm = 1; bus.src_mask = 4'b0001;
        step();
        bus.arm = 0; bus.wd_triggered = 1;
        step();
        bus.wd_triggered = 0;
        for (int i = 0; i < 8; i++) step();
        n_tests++;
        if (flags() !== {3'd3, 3'b001}) begin
            n_fail++; $display("FAIL reach_restart: got %b expected 011001", flags());
        end
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({flags(), bus.fault_count} !== {3'd0, 3'b001, 4'd0}) begin
            n_fail++; $display("FAIL async_reset: got %b/%0d expected 000001/0", flags(), bus.fault_count);
        end
        rstn = 1'b1;
        step();
        n_tests++;
        if (flags() !== {3'd0, 3'b100}) begin
            n_fail++; $display("FAIL post_reset_idle: got %b expected 000100", flags());
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_heartbeat();
        test_mask_zero();
        test_force_warn();
        test_trigger_wins();
        test_lockout();
        test_reset_mid_restart();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/watchdog_supervisor.md
Name: watchdog_supervisor

Overview:
Controller that sequences the watchdog_timer in the AM radio FPGA. Collects liveness kicks from up to N_SRC subsystems (control bus, DDS, DMA, ADC path). Issues one heartbeat to the watchdog only when every masked subsystem has kicked. Handles arming, forced trips, RF muting on fault, timed watchdog restart and lockout after repeated faults.

Parameters:
N_SRC, 4, number of kick requesters
HOLDOFF_CYCLES, 1024, cycles spent in FAULT with RF muted before restart
RESTART_CYCLES, 2, cycles wd_rstn is held low during restart
MAX_FAULTS, 3, faults before LOCKOUT
FCNT_W, 4, width of fault_count

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
arm  in  1  pulse: start supervision (IDLE only)
disarm  in  1  pulse: return to IDLE (ARMED only)
src_mask  in  N_SRC  sources required to kick; latched on arm
kick  in  N_SRC  per-source liveness pulses
sw_force  in  1  pulse: request forced watchdog trip
clear_lockout  in  1  pulse: leave LOCKOUT
wd_triggered  in  1  watchdog trip status
wd_warning  in  1  watchdog near-timeout status
wd_rstn  out  1  watchdog reset, active-low
wd_enable  out  1  watchdog enable
wd_heartbeat  out  1  one-cycle heartbeat pulse
wd_force_reset  out  1  one-cycle forced trip pulse
rf_mute  out  1  mute RF output
warn_irq  out  1  one-cycle pulse on wd_warning rise while ARMED
kick_pending  out  N_SRC  masked sources not yet kicked this round
fault_count  out  FCNT_W  faults since last lockout clear, saturating
state  out  3  IDLE=0 ARMED=1 FAULT=2 RESTART=3 LOCKOUT=4

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, wd_rstn=0, wd_enable=0, wd_heartbeat=0, wd_force_reset=0, rf_mute=1, warn_irq=0, kick_pending=0, fault_count=0, latched mask=0, seen=0.
- IDLE: wd_rstn=1, wd_enable=0, rf_mute=0. On arm: latch src_mask, clear seen, go to ARMED. wd_enable=1 on the same edge.
- ARMED: seen accumulates kick & mask. kick_pending = mask & ~seen.
  - Round complete when ((seen | kick) & mask) == mask and mask != 0. Then: wd_heartbeat=1 on the next edge for exactly 1 cycle, and seen clears to 0. Kicks in the completing cycle are consumed, not carried over.
  - mask == 0: never heartbeat; the watchdog times out by design.
  - Repeated kicks from one source within a round have no extra effect.
- sw_force in ARMED: wd_force_reset=1 for 1 cycle. Ignored in every other state.
- warn_irq: 1-cycle pulse on a 0->1 edge of wd_warning sampled in ARMED.
- wd_triggered=1 in ARMED: go to FAULT on the next edge.
  - Same edge: rf_mute=1, wd_enable=0, fault_count increments (saturates at all-ones).
  - Wins over a completing kick (no heartbeat), over disarm, and over sw_force.
- disarm in ARMED (no trigger): go to IDLE, wd_enable=0, seen cleared.
- FAULT: hold for exactly HOLDOFF_CYCLES cycles using an internal counter. Then:
  - fault_count >= MAX_FAULTS: go to LOCKOUT.
  - Otherwise: go to RESTART.
  - arm, disarm, kicks and wd_triggered are ignored.
- RESTART: wd_rstn=0 for exactly RESTART_CYCLES cycles. Then go to ARMED with wd_rstn=1, wd_enable=1, seen cleared, latched mask retained. rf_mute=0 on entry to ARMED. wd_triggered is ignored.
- LOCKOUT: rf_mute=1, wd_enable=0, wd_rstn=1. Only clear_lockout has effect: go to IDLE and clear fault_count to 0.
- Asserting rstn mid-operation returns everything to reset values immediately, including mid-FAULT or mid-RESTART.
- Internal holdoff counter width: clog2(HOLDOFF_CYCLES+1). Counters never wrap.

Test Plan:
- Reset, then arm with src_mask=4'b1011; kick bits 0, 1, 3 on separate cycles -> wd_heartbeat high exactly 1 cycle, 1 cycle after the bit-3 kick. kick_pending goes 1011→1010→1000→0000→1011.
- Armed with mask=4'b0011, kick=4'b0011 in the same cycle as wd_triggered=1 -> no heartbeat; state=FAULT, rf_mute=1, wd_enable=0, fault_count=1 on the next edge.
- HOLDOFF_CYCLES=8, RESTART_CYCLES=2, one fault -> FAULT for 8 cycles, wd_rstn=0 for 2 cycles, then ARMED with wd_enable=1 and rf_mute=0.
- MAX_FAULTS=3, three consecutive triggers -> third holdoff ends in LOCKOUT, rf_mute stays 1, arm ignored. clear_lockout -> IDLE, fault_count=0.
- sw_force in ARMED -> wd_force_reset 1 cycle. sw_force in IDLE -> no pulse. wd_warning 0→1 in ARMED -> warn_irq 1 cycle. In IDLE -> no pulse.
- Drop rstn low during RESTART -> wd_rstn=0, wd_enable=0, rf_mute=1, state=IDLE immediately. After release -> wd_rstn=1, rf_mute=0 on the first clock.
